// File: rtl/cmos_window_packer.sv
// rtl/cmos_window_packer.sv - crops a window from an RGB565 CMOS stream and packs pixel pairs into 32-bit FIFO writes
module cmos_window_packer #(
    parameter int H_START = 0,
    parameter int H_SIZE  = 640,
    parameter int V_START = 0,
    parameter int V_SIZE  = 480,
    parameter int CNT_W   = 12
) (
    input  logic        cmos_pclk,
    input  logic        rst_n,
    input  logic        cmos_frame_vsync,
    input  logic        cmos_frame_href,
    input  logic        cmos_frame_clken,
    input  logic [15:0] cmos_frame_data,
    input  logic        fifo_full,
    output logic        fifo_wr_en,
    output logic [31:0] fifo_wr_data,
    output logic        frame_start,
    output logic        frame_done,
    output logic        frame_overflow
);

    typedef enum logic [1:0] {IDLE, ACTIVE, DROP} state_t;

    localparam logic [CNT_W-1:0] H_FIRST  = CNT_W'(H_START);
    localparam logic [CNT_W-1:0] V_FIRST  = CNT_W'(V_START);
    localparam logic [CNT_W:0]   H_SZ     = (CNT_W+1)'(H_SIZE);
    localparam logic [CNT_W:0]   V_SZ     = (CNT_W+1)'(V_SIZE);
    localparam logic [CNT_W-1:0] H_LAST_O = CNT_W'(H_SIZE - 1);
    localparam logic [CNT_W-1:0] V_LAST_O = CNT_W'(V_SIZE - 1);

    state_t state, state_next;

    logic             vsync_r, vsync_d, href_r, href_d, clken_r;
    logic [15:0]      data_r;
    logic [CNT_W-1:0] pix_cnt, line_cnt;
    logic [15:0]      pack;
    logic             half;

    logic             vsync_rise, href_rise, href_fall, pix_valid;
    logic [CNT_W-1:0] cur_pix, pix_off, line_off;
    logic             in_win, take, pair_done, wr, ovf, done, last_pix;

    // The first pixel of a line arrives on the href rising edge, before pix_cnt has been cleared.
    always_comb begin
        vsync_rise = vsync_r & ~vsync_d;
        href_rise  = href_r & ~href_d;
        href_fall  = ~href_r & href_d;
        pix_valid  = clken_r & href_r;
        cur_pix    = href_rise ? '0 : pix_cnt;
        pix_off    = cur_pix - H_FIRST;
        line_off   = line_cnt - V_FIRST;
        in_win     = ({1'b0, pix_off} < H_SZ) && ({1'b0, line_off} < V_SZ);
        last_pix   = (pix_off == H_LAST_O) && (line_off == V_LAST_O);
        take       = (state == ACTIVE) && !vsync_rise && pix_valid && in_win;
        pair_done  = take && half;
        wr         = pair_done && !fifo_full;
        ovf        = pair_done && fifo_full;
        done       = wr && last_pix;
    end

    always_comb begin
        state_next = state;
        if (vsync_rise) begin
            state_next = ACTIVE;
        end else if (state == ACTIVE) begin
            if (ovf) begin
                state_next = DROP;
            end else if (done) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_r        <= 1'b0;
            vsync_d        <= 1'b0;
            href_r         <= 1'b0;
            href_d         <= 1'b0;
            clken_r        <= 1'b0;
            data_r         <= '0;
            pix_cnt        <= '0;
            line_cnt       <= '0;
            pack           <= '0;
            half           <= 1'b0;
            fifo_wr_en     <= 1'b0;
            fifo_wr_data   <= '0;
            frame_start    <= 1'b0;
            frame_done     <= 1'b0;
            frame_overflow <= 1'b0;
        end else begin
            vsync_r     <= cmos_frame_vsync;
            vsync_d     <= vsync_r;
            href_r      <= cmos_frame_href;
            href_d      <= href_r;
            clken_r     <= cmos_frame_clken;
            data_r      <= cmos_frame_data;
            frame_start <= vsync_rise;
            fifo_wr_en  <= wr;
            frame_done  <= done;

            if (ovf) begin
                frame_overflow <= 1'b1;
            end
            if (wr) begin
                fifo_wr_data <= {data_r, pack};
            end

            if (vsync_rise) begin
                pix_cnt <= '0;
            end else if (href_rise) begin
                pix_cnt <= pix_valid ? CNT_W'(1) : '0;
            end else if (pix_valid && pix_cnt != '1) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end

            if (vsync_rise) begin
                line_cnt <= '0;
            end else if (href_fall && line_cnt != '1) begin
                line_cnt <= line_cnt + CNT_W'(1);
            end

            // An orphan pixel left at the end of a line is discarded.
            if (vsync_rise || href_fall) begin
                half <= 1'b0;
            end else if (take) begin
                half <= ~half;
            end

            if (take && !half) begin
                pack <= data_r;
            end
        end
    end

endmodule
